mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline. It sits between the execute stage and write-back, and consumes the 157-bit execute-to-memory bus. It performs data-memory loads and stores against a synchronous-read data RAM, with size/alignment handling and address-error detection. It also holds the result until write-back accepts it, then emits the 121-bit memory-to-write-back bus.

---
 rtl/pipeline_pkg.sv | 51 +++++
 rtl/load_align.sv | 18 +
 rtl/mem_stage.sv | 69 ++++++
 tb/tb_mem_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared bus layouts, mem_control fields and mem-stage FSM encoding
package pipeline_pkg;
  localparam int EXE_MEM_W = 157;
  localparam int MEM_WB_W = 121;
  localparam int MC_LOAD = 5;
  localparam int MC_STORE = 4;
  localparam int MC_SIZE_HI = 3;
  localparam int MC_SIZE_LO = 2;
  localparam int MC_SIGN = 1;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} mem_state_e;
  typedef struct packed {
    logic [5:0]  mem_control;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        eret;
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] pc;
    logic        brk;
  } exe_mem_t;
  typedef struct packed {
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        eret;
    logic [31:0] pc;
    logic        brk;
    logic        adel;
    logic        ades;
  } mem_wb_t;
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half of a RAM word and sign- or zero-extends it
module load_align
  import pipeline_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    data = size == SZ_BYTE ? {{24{sign & b[7]}}, b} : size == SZ_HALF ? {{16{sign & h[15]}}, h} : rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage issuing data-RAM loads/stores and holding the result until write-back accepts it
module mem_stage
  import pipeline_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MEM_valid,
  input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
  input  logic                 WB_allow_in,
  input  logic                 cancel,
  input  logic [31:0]          dm_rdata,
  output logic [31:0]          dm_addr,
  output logic [3:0]           dm_wen,
  output logic [31:0]          dm_wdata,
  output logic                 MEM_over,
  output logic [MEM_WB_W-1:0]  MEM_WB_bus,
  output logic [4:0]           MEM_wdest,
  output logic [31:0]          MEM_pc
);
  exe_mem_t    e;
  mem_wb_t     w;
  mem_state_e  state_q, state_d;
  logic [31:0] buf_q, buf_d, ld_data, mem_result;
  logic [1:0]  a, sz;
  logic        ld, st, mis, idle, kill, unused_rsvd;
  assign e = EXE_MEM_bus_r;
  assign a = e.exe_result[1:0];
  assign sz = e.mem_control[MC_SIZE_HI:MC_SIZE_LO];
  assign ld = e.mem_control[MC_LOAD];
  assign st = e.mem_control[MC_STORE];
  assign unused_rsvd = e.mem_control[0];
  load_align u_align (
    .rdata (dm_rdata),
    .addr  (a),
    .size  (sz),
    .sign  (e.mem_control[MC_SIGN]),
    .data  (ld_data)
  );
  always_comb begin
    idle = state_q == S_IDLE;
    kill = cancel | reset;
    mis = (ld | st) & (sz == SZ_BYTE ? 1'b0 : sz == SZ_HALF ? a[0] : |a);
    MEM_over = MEM_valid & ~kill & ~(idle & ld & ~mis);
    dm_wen = idle & MEM_valid & ~kill & st & ~mis
      ? (sz == SZ_BYTE ? 4'b0001 << a : sz == SZ_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111)
      : 4'b0000;
    dm_wdata = sz == SZ_BYTE ? {4{e.store_data[7:0]}} : sz == SZ_HALF ? {2{e.store_data[15:0]}} : e.store_data;
    mem_result = state_q == S_DONE ? buf_q : (ld & ~mis) ? ld_data : e.exe_result;
    buf_d = MEM_over & state_q != S_DONE ? mem_result : buf_q;
    state_d = cancel ? S_IDLE
      : idle ? (MEM_valid & ld & ~mis ? S_WAIT : MEM_over & ~WB_allow_in ? S_DONE : S_IDLE)
      : WB_allow_in ? S_IDLE : S_DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      buf_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
    end
  end
  assign w = '{e.rf_wen, e.rf_wdest, mem_result, e.lo_result, e.hi_write, e.lo_write, e.mfhi, e.mflo,
               e.mtc0, e.mfc0, e.cp0r_addr, e.syscall, e.eret, e.pc, e.brk, ld & mis, st & mis};
  assign MEM_WB_bus = w;
  assign dm_addr = e.exe_result;
  assign MEM_wdest = e.rf_wdest & {5{MEM_valid}};
  assign MEM_pc = e.pc;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage against a byte-enabled synchronous RAM model
module tb_mem_stage;
  logic clk = 0, reset = 1, MEM_valid = 0, WB_allow_in = 0, cancel = 0;
  logic [156:0] bus = '0;
  logic [31:0] dm_rdata = '0;
  logic [31:0] dm_addr, dm_wdata, MEM_pc;
  logic [3:0] dm_wen;
  logic MEM_over;
  logic [120:0] wb;
  logic [4:0] MEM_wdest;
  logic [31:0] ram [256];
  logic [31:0] shadow [256];
  int wr_cnt = 0, n_chk = 0, n_fail = 0;
  typedef struct {logic [31:0] res, pc; logic adel, ades;} exp_t;
  exp_t sb[$];
  localparam logic [5:0] LB = 6'b100010, LBU = 6'b100000, LH = 6'b100110, LHU = 6'b100100, LW = 6'b101000;
  localparam logic [5:0] SB = 6'b010000, SH = 6'b010100, SW = 6'b011000, ADDU = 6'b000000;
  always #5 clk = ~clk;
  mem_stage dut (
    .clk(clk), .reset(reset), .MEM_valid(MEM_valid), .EXE_MEM_bus_r(bus), .WB_allow_in(WB_allow_in),
    .cancel(cancel), .dm_rdata(dm_rdata), .dm_addr(dm_addr), .dm_wen(dm_wen), .dm_wdata(dm_wdata),
    .MEM_over(MEM_over), .MEM_WB_bus(wb), .MEM_wdest(MEM_wdest), .MEM_pc(MEM_pc)
  );
  always @(posedge clk) begin
    dm_rdata <= ram[dm_addr[9:2]];
    for (int i = 0; i < 4; i++) if (dm_wen[i]) ram[dm_addr[9:2]][8*i +: 8] = dm_wdata[8*i +: 8];
    if (|dm_wen) wr_cnt++;
  end
  function automatic logic [156:0] mk(input logic [5:0] mc, input logic [31:0] sd, er, pc, input logic [4:0] wd);
    return {mc, sd, er, 32'h0, 6'b0, 8'h0, 2'b0, 1'b1, wd, pc, 1'b0};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_accept(input int stall, input int max, output int cyc, output bit got);
    got = 0;
    cyc = 0;
    WB_allow_in = (stall == 0);
    while (!got && cyc < max) begin
      @(negedge clk);
      cyc++;
      got = MEM_over && WB_allow_in;
      if (!got) begin
        tick();
        WB_allow_in = (cyc >= stall);
      end
    end
  endtask
  task automatic test_reset();
    reset = 1; MEM_valid = 1; cancel = 0; WB_allow_in = 1;
    bus = mk(SW, 32'h55, 32'h100, 32'h0, 5'd3);
    repeat (3) tick();
    @(negedge clk);
    n_chk++; if (MEM_over !== 1'b0) begin n_fail++; $display("FAIL reset_over: got %b want 0", MEM_over); end
    n_chk++; if (dm_wen !== 4'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0000", dm_wen); end
    n_chk++; if (MEM_wdest !== 5'd3) begin n_fail++; $display("FAIL reset_wdest: got %0d want 3", MEM_wdest); end
    tick();
    n_chk++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL reset_writes: got %0d want 0", wr_cnt); end
    reset = 0; MEM_valid = 0;
    @(negedge clk);
    n_chk++; if (MEM_over !== 1'b0 || MEM_wdest !== 5'd0) begin n_fail++; $display("FAIL idle_invalid: over %b wdest %0d want 0 0", MEM_over, MEM_wdest); end
    tick();
  endtask
  task automatic test_lb();
    int cyc; bit got; exp_t ex; logic [31:0] pc;
    ram[8'h40] = 32'h80FF_1234;
    for (int i = 0; i < 2; i++) begin
      pc = 32'hBFC0_0010 + 32'(i * 4);
      bus = mk(i == 0 ? LB : LBU, 32'h0, 32'h103, pc, 5'd4);
      MEM_valid = 1;
      sb.push_back('{i == 0 ? 32'hFFFF_FF80 : 32'h0000_0080, pc, 1'b0, 1'b0});
      wait_accept(0, 8, cyc, got);
      ex = sb.pop_front();
      n_chk++; if (!got || cyc != 2) begin n_fail++; $display("FAIL lb_latency[%0d]: got %0d cycles want 2", i, cyc); end
      n_chk++; if (wb[114:83] !== ex.res) begin n_fail++; $display("FAIL lb_result[%0d]: got %h want %h", i, wb[114:83], ex.res); end
      n_chk++; if (wb[34:3] !== ex.pc || MEM_pc !== ex.pc || wb[1:0] !== 2'b00) begin n_fail++; $display("FAIL lb_fields[%0d]: pc %h err %b want %h 00", i, wb[34:3], wb[1:0], ex.pc); end
      n_chk++; if (MEM_wdest !== 5'd4) begin n_fail++; $display("FAIL lb_wdest: got %0d want 4", MEM_wdest); end
      tick();
    end
    MEM_valid = 0;
  endtask
  task automatic test_sh();
    int cyc, w0; bit got; exp_t ex;
    w0 = wr_cnt;
    bus = mk(SH, 32'h0000_BEEF, 32'h102, 32'h100, 5'd5);
    MEM_valid = 1; WB_allow_in = 0;
    sb.push_back('{32'h102, 32'h100, 1'b0, 1'b0});
    @(negedge clk);
    n_chk++; if (dm_wen !== 4'b1100 || dm_wdata !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL sh_write: wen %b data %h want 1100 beefbeef", dm_wen, dm_wdata); end
    n_chk++; if (MEM_over !== 1'b1) begin n_fail++; $display("FAIL sh_over: got %b want 1", MEM_over); end
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      n_chk++; if (dm_wen !== 4'b0 || MEM_over !== 1'b1 || wb[114:83] !== 32'h102) begin n_fail++; $display("FAIL sh_hold[%0d]: wen %b over %b res %h want 0000 1 102", k, dm_wen, MEM_over, wb[114:83]); end
    end
    tick();
    wait_accept(0, 4, cyc, got);
    ex = sb.pop_front();
    n_chk++; if (!got || cyc != 1 || wb[114:83] !== ex.res || wb[0] !== ex.ades) begin n_fail++; $display("FAIL sh_accept: got %b cyc %0d res %h want 1 1 %h", got, cyc, wb[114:83], ex.res); end
    tick();
    MEM_valid = 0;
    n_chk++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL sh_once: got %0d writes want 1", wr_cnt - w0); end
    n_chk++; if (ram[8'h40] !== 32'hBEEF_1234) begin n_fail++; $display("FAIL sh_ram: got %h want beef1234", ram[8'h40]); end
  endtask
  task automatic test_misaligned();
    int cyc, w0; bit got; exp_t ex;
    w0 = wr_cnt;
    bus = mk(LW, 32'h0, 32'h101, 32'h200, 5'd6);
    MEM_valid = 1;
    sb.push_back('{32'h0000_0101, 32'h200, 1'b1, 1'b0});
    wait_accept(0, 4, cyc, got);
    ex = sb.pop_front();
    n_chk++; if (!got || cyc != 1 || dm_wen !== 4'b0) begin n_fail++; $display("FAIL lw_mis_timing: cyc %0d wen %b want 1 0000", cyc, dm_wen); end
    n_chk++; if (wb[114:83] !== ex.res || wb[1:0] !== {ex.adel, ex.ades}) begin n_fail++; $display("FAIL lw_mis_result: res %h err %b want %h 10", wb[114:83], wb[1:0], ex.res); end
    tick();
    bus = mk(SW, 32'h1111_2222, 32'h202, 32'h204, 5'd6);
    sb.push_back('{32'h0000_0202, 32'h204, 1'b0, 1'b1});
    wait_accept(0, 4, cyc, got);
    ex = sb.pop_front();
    n_chk++; if (!got || cyc != 1 || dm_wen !== 4'b0 || wb[1:0] !== {ex.adel, ex.ades} || wb[114:83] !== ex.res) begin n_fail++; $display("FAIL sw_mis: cyc %0d wen %b err %b res %h want 1 0000 01 %h", cyc, dm_wen, wb[1:0], wb[114:83], ex.res); end
    tick();
    MEM_valid = 0;
    n_chk++; if (wr_cnt !== w0) begin n_fail++; $display("FAIL mis_nowrite: got %0d writes want 0", wr_cnt - w0); end
  endtask
  task automatic test_lw_stall();
    int cyc; bit got; exp_t ex;
    ram[8'h80] = 32'hCAFE_0001;
    bus = mk(LW, 32'h0, 32'h200, 32'h300, 5'd7);
    MEM_valid = 1; WB_allow_in = 0;
    sb.push_back('{32'hCAFE_0001, 32'h300, 1'b0, 1'b0});
    @(negedge clk);
    n_chk++; if (MEM_over !== 1'b0) begin n_fail++; $display("FAIL lw_issue_over: got %b want 0", MEM_over); end
    tick();
    @(negedge clk);
    n_chk++; if (MEM_over !== 1'b1 || wb[114:83] !== 32'hCAFE_0001) begin n_fail++; $display("FAIL lw_wait: over %b res %h want 1 cafe0001", MEM_over, wb[114:83]); end
    ram[8'h80] = 32'h1234_5678;
    tick();
    @(negedge clk);
    n_chk++; if (MEM_over !== 1'b1 || wb[114:83] !== 32'hCAFE_0001) begin n_fail++; $display("FAIL lw_done_hold: over %b res %h want 1 cafe0001", MEM_over, wb[114:83]); end
    tick();
    wait_accept(0, 4, cyc, got);
    ex = sb.pop_front();
    n_chk++; if (!got || cyc != 1 || wb[114:83] !== ex.res) begin n_fail++; $display("FAIL lw_done_accept: cyc %0d res %h want 1 %h", cyc, wb[114:83], ex.res); end
    tick();
    MEM_valid = 0;
  endtask
  task automatic test_cancel();
    int cyc, w0; bit got; exp_t ex;
    ram[8'h80] = 32'h0BAD_F00D;
    bus = mk(LW, 32'h0, 32'h200, 32'h400, 5'd8);
    MEM_valid = 1; WB_allow_in = 1; cancel = 0;
    @(negedge clk);
    tick();
    cancel = 1;
    @(negedge clk);
    n_chk++; if (MEM_over !== 1'b0) begin n_fail++; $display("FAIL cancel_wait: over %b want 0", MEM_over); end
    tick();
    cancel = 0;
    bus = mk(ADDU, 32'h0, 32'h1234_0000, 32'h404, 5'd8);
    sb.push_back('{32'h1234_0000, 32'h404, 1'b0, 1'b0});
    wait_accept(0, 4, cyc, got);
    ex = sb.pop_front();
    n_chk++; if (!got || cyc != 1 || wb[114:83] !== ex.res) begin n_fail++; $display("FAIL cancel_next: cyc %0d res %h want 1 %h", cyc, wb[114:83], ex.res); end
    tick();
    w0 = wr_cnt;
    cancel = 1;
    bus = mk(SW, 32'hDEAD_BEEF, 32'h204, 32'h408, 5'd0);
    @(negedge clk);
    n_chk++; if (dm_wen !== 4'b0 || MEM_over !== 1'b0) begin n_fail++; $display("FAIL cancel_store: wen %b over %b want 0000 0", dm_wen, MEM_over); end
    tick();
    cancel = 0; MEM_valid = 0;
    n_chk++; if (wr_cnt !== w0) begin n_fail++; $display("FAIL cancel_nowrite: got %0d writes want 0", wr_cnt - w0); end
  endtask
  task automatic test_reset_mid_wait();
    int cyc; bit got; exp_t ex;
    bus = mk(LW, 32'h0, 32'h200, 32'h500, 5'd9);
    MEM_valid = 1; WB_allow_in = 0;
    @(negedge clk);
    tick();
    reset = 1;
    @(negedge clk);
    n_chk++; if (MEM_over !== 1'b0) begin n_fail++; $display("FAIL rst_wait_over: got %b want 0", MEM_over); end
    tick();
    reset = 0;
    @(negedge clk);
    n_chk++; if (MEM_over !== 1'b0 || dm_wen !== 4'b0) begin n_fail++; $display("FAIL rst_to_idle: over %b wen %b want 0 0000", MEM_over, dm_wen); end
    sb.push_back('{ram[8'h80], 32'h500, 1'b0, 1'b0});
    tick();
    wait_accept(0, 4, cyc, got);
    ex = sb.pop_front();
    n_chk++; if (!got || cyc != 1 || wb[114:83] !== ex.res) begin n_fail++; $display("FAIL rst_reissue: cyc %0d res %h want 1 %h", cyc, wb[114:83], ex.res); end
    tick();
    MEM_valid = 0;
  endtask
  task automatic test_back_to_back();
    logic [5:0] ops [9];
    logic [5:0] mc;
    logic [31:0] addr, sd, word, sh_w, res, pc;
    logic mis;
    int cyc, stall, lat; bit got; exp_t ex;
    ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW, ADDU};
    for (int i = 0; i < 4; i++) begin ram[8'hC0 + i] = $urandom; shadow[8'hC0 + i] = ram[8'hC0 + i]; end
    for (int n = 0; n < 24; n++) begin
      mc = ops[$urandom_range(0, 8)];
      addr = 32'h300 + 32'($urandom_range(0, 15));
      sd = $urandom;
      stall = $urandom_range(0, 2);
      pc = 32'h8000_0000 + 32'(n * 4);
      word = shadow[addr[9:2]];
      mis = (mc[5] || mc[4]) && ((mc[3:2] == 2'b01 && addr[0]) || (mc[3] && addr[1:0] != 2'b00));
      sh_w = word >> (8 * addr[1:0]);
      res = (!mc[5] || mis) ? addr
          : mc[3:2] == 2'b00 ? (mc[1] ? {{24{sh_w[7]}}, sh_w[7:0]} : {24'h0, sh_w[7:0]})
          : mc[3:2] == 2'b01 ? (mc[1] ? {{16{sh_w[15]}}, sh_w[15:0]} : {16'h0, sh_w[15:0]})
          : word;
      lat = (mc[5] && !mis) ? 2 : 1;
      sb.push_back('{res, pc, mc[5] && mis, mc[4] && mis});
      if (mc[4] && !mis) begin
        if (mc[3:2] == 2'b00) shadow[addr[9:2]][8 * addr[1:0] +: 8] = sd[7:0];
        else if (mc[3:2] == 2'b01) shadow[addr[9:2]][8 * addr[1:0] +: 16] = sd[15:0];
        else shadow[addr[9:2]] = sd;
      end
      bus = mk(mc, sd, addr, pc, 5'(n));
      MEM_valid = 1;
      wait_accept(stall, 8, cyc, got);
      ex = sb.pop_front();
      n_chk++; if (!got || cyc != (lat > stall + 1 ? lat : stall + 1)) begin n_fail++; $display("FAIL b2b_latency[%0d]: mc %b got %0d cycles want %0d", n, mc, cyc, lat > stall + 1 ? lat : stall + 1); end
      n_chk++; if (wb[114:83] !== ex.res || wb[34:3] !== ex.pc || wb[1:0] !== {ex.adel, ex.ades}) begin n_fail++; $display("FAIL b2b_result[%0d]: mc %b addr %h res %h err %b want %h %b%b", n, mc, addr, wb[114:83], wb[1:0], ex.res, ex.adel, ex.ades); end
      tick();
    end
    MEM_valid = 0;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (ram[8'hC0 + i] !== shadow[8'hC0 + i]) begin n_fail++; $display("FAIL b2b_ram[%0d]: got %h want %h", i, ram[8'hC0 + i], shadow[8'hC0 + i]); end
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = '0; shadow[i] = '0; end
    test_reset();
    test_lb();
    test_sh();
    test_misaligned();
    test_lw_stall();
    test_cancel();
    test_reset_mid_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
